// File: rtl/vga_pkg.sv
// vga_pkg: definitions shared by the pixel sink and its plot FIFO.
//   SCREEN_W / SCREEN_H : visible raster size (160 x 120)
//   FB_WORDS / FB_AW    : frame-buffer word count and address width
//   state_e             : sink controller states (RUN, CLEAR)
//   pixel_t             : one queued plot {x, y, colour}
//   pixelAddr()         : linear frame-buffer address y*160+x
//   inScreen()          : true when (x,y) lies inside the raster
package vga_pkg;

  localparam int unsigned FB_AW = 15;

  localparam logic [7:0]       SCREEN_W = 8'd160;
  localparam logic [6:0]       SCREEN_H = 7'd120;
  localparam logic [FB_AW-1:0] FB_WORDS = 15'd19200;

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } state_e;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } pixel_t;

  // 160 = 128 + 32, so y*160 becomes two shifts and an add.
  function automatic logic [FB_AW-1:0] pixelAddr(input logic [7:0] px, input logic [6:0] py);
    logic [FB_AW-1:0] yWide;
    logic [FB_AW-1:0] xWide;
    yWide = {{(FB_AW-7){1'b0}}, py};
    xWide = {{(FB_AW-8){1'b0}}, px};
    return (yWide << 7) + (yWide << 5) + xWide;
  endfunction

  function automatic logic inScreen(input logic [7:0] px, input logic [6:0] py);
    return (px < SCREEN_W) && (py < SCREEN_H);
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo: DEPTH-entry synchronous FIFO of pixel_t plots.
//   clock_i, resetn_i : clock and asynchronous active-low reset
//   push_i, data_i    : enqueue data_i (ignored when full unless popping too)
//   pop_i, data_o     : dequeue; data_o always shows the head entry
//   flush_i           : empty the FIFO; overrides push and pop
//   full_o, empty_o   : occupancy flags
module pixel_fifo
  import vga_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic   clock_i,
  input  logic   resetn_i,
  input  logic   push_i,
  input  logic   pop_i,
  input  logic   flush_i,
  input  pixel_t data_i,
  output pixel_t data_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  pixel_t        mem_q [DEPTH];
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          doPush;
  logic          doPop;

  assign full_o  = (count_q == FULL_COUNT);
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rdPtr_q];

  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // legal then. Flush discards everything, including this cycle's push.
  assign doPop  = pop_i && !empty_o && !flush_i;
  assign doPush = push_i && (!full_o || doPop) && !flush_i;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (doPush) wrPtr_d = wrPtr_q + 1'b1;
      if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
      case ({doPush, doPop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state.
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clock_i) begin
    if (doPush) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/pixel_sink.sv
// pixel_sink: receives plot strobes, queues them and writes the frame buffer;
// also runs a full-screen clear sweep on request.
//   clock, resetn      : clock and asynchronous active-low reset
//   plot, x, y, colour : one pixel write request per cycle
//   clear_req          : start a clear sweep (ignored while one is running)
//   wr_en, wr_addr, wr_data : registered frame-buffer write port
//   busy               : high while the sweep is writing
//   clear_done         : one-cycle pulse after the final sweep write
//   overflow, oob      : sticky drop flags (FIFO full / off-screen plot)
module pixel_sink
  import vga_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter logic [2:0]  CLEAR_COLOUR = 3'b000
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             plot,
  input  logic [7:0]       x,
  input  logic [6:0]       y,
  input  logic [2:0]       colour,
  input  logic             clear_req,
  output logic             wr_en,
  output logic [FB_AW-1:0] wr_addr,
  output logic [2:0]       wr_data,
  output logic             busy,
  output logic             clear_done,
  output logic             overflow,
  output logic             oob
);

  state_e           state_q, state_d;
  logic [FB_AW-1:0] sweepAddr_q, sweepAddr_d;
  logic             wrEn_q, wrEn_d;
  logic [FB_AW-1:0] wrAddr_q, wrAddr_d;
  logic [2:0]       wrData_q, wrData_d;
  logic             busy_q, busy_d;
  logic             clearDone_q, clearDone_d;
  logic             overflow_q, overflow_d;
  logic             oob_q, oob_d;

  logic             plotValid;
  logic             plotBad;
  logic             sweepEnd;
  pixel_t           pixelIn;
  pixel_t           fifoHead;
  logic             fifoPush;
  logic             fifoPop;
  logic             fifoFlush;
  logic             fifoFull;
  logic             fifoEmpty;

  assign plotValid = plot && inScreen(x, y);
  assign plotBad   = plot && !inScreen(x, y);
  // The counter steps past the last address once, marking the done cycle.
  assign sweepEnd  = (sweepAddr_q == FB_WORDS);
  assign pixelIn   = '{x: x, y: y, colour: colour};

  pixel_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock_i (clock),
    .resetn_i(resetn),
    .push_i  (fifoPush),
    .pop_i   (fifoPop),
    .flush_i (fifoFlush),
    .data_i  (pixelIn),
    .data_o  (fifoHead),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= RUN;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (clear_req) state_d = CLEAR;
      CLEAR:   if (sweepEnd)  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Output and datapath logic. In RUN an empty FIFO is bypassed so a lone
  // plot is written the very next cycle; once anything is queued, new plots
  // go behind it to keep order. clear_req takes the FIFO away without
  // popping, since the sweep erases those pixels anyway.
  always_comb begin
    wrEn_d      = 1'b0;
    wrAddr_d    = wrAddr_q;
    wrData_d    = wrData_q;
    busy_d      = busy_q;
    clearDone_d = 1'b0;
    sweepAddr_d = sweepAddr_q;
    overflow_d  = overflow_q;
    oob_d       = oob_q | plotBad;
    fifoPush    = 1'b0;
    fifoPop     = 1'b0;
    fifoFlush   = 1'b0;

    unique case (state_q)
      RUN: begin
        if (clear_req) begin
          fifoFlush   = 1'b1;
          wrEn_d      = 1'b1;
          wrAddr_d    = '0;
          wrData_d    = CLEAR_COLOUR;
          sweepAddr_d = {{(FB_AW-1){1'b0}}, 1'b1};
          busy_d      = 1'b1;
        end else if (!fifoEmpty) begin
          fifoPop  = 1'b1;
          fifoPush = plotValid;
          wrEn_d   = 1'b1;
          wrAddr_d = pixelAddr(fifoHead.x, fifoHead.y);
          wrData_d = fifoHead.colour;
        end else if (plotValid) begin
          wrEn_d   = 1'b1;
          wrAddr_d = pixelAddr(x, y);
          wrData_d = colour;
        end
      end

      CLEAR: begin
        if (sweepEnd) begin
          clearDone_d = 1'b1;
          busy_d      = 1'b0;
          sweepAddr_d = '0;
        end else begin
          wrEn_d      = 1'b1;
          wrAddr_d    = sweepAddr_q;
          wrData_d    = CLEAR_COLOUR;
          sweepAddr_d = sweepAddr_q + 1'b1;
        end
        if (plotValid) begin
          if (fifoFull) overflow_d = 1'b1;
          else          fifoPush   = 1'b1;
        end
      end

      default: ;
    endcase
  end

  // Registered outputs, sweep counter and sticky flags.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sweepAddr_q <= '0;
      wrEn_q      <= 1'b0;
      wrAddr_q    <= '0;
      wrData_q    <= '0;
      busy_q      <= 1'b0;
      clearDone_q <= 1'b0;
      overflow_q  <= 1'b0;
      oob_q       <= 1'b0;
    end else begin
      sweepAddr_q <= sweepAddr_d;
      wrEn_q      <= wrEn_d;
      wrAddr_q    <= wrAddr_d;
      wrData_q    <= wrData_d;
      busy_q      <= busy_d;
      clearDone_q <= clearDone_d;
      overflow_q  <= overflow_d;
      oob_q       <= oob_d;
    end
  end

  assign wr_en      = wrEn_q;
  assign wr_addr    = wrAddr_q;
  assign wr_data    = wrData_q;
  assign busy       = busy_q;
  assign clear_done = clearDone_q;
  assign overflow   = overflow_q;
  assign oob        = oob_q;

endmodule
